// File: rtl/minha_fpu.sv
// Single-precision (binary32) adder/subtractor with round-to-nearest-even
// and one registered output stage. Denormal inputs are read as signed zero.
module minha_fpu (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] Op_A_in,
  input  logic [31:0] Op_B_in,
  input  logic        op_select,
  output logic [31:0] data_out,
  output logic [3:0]  status_out
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic        w_sa, w_sb;
  logic [7:0]  w_ea, w_eb;
  logic [22:0] w_fa, w_fb;
  logic        w_nan_a, w_nan_b, w_inf_a, w_inf_b, w_zero_a, w_zero_b;

  assign w_sa     = Op_A_in[31];
  assign w_sb     = Op_B_in[31] ^ op_select;
  assign w_ea     = Op_A_in[30:23];
  assign w_eb     = Op_B_in[30:23];
  assign w_fa     = Op_A_in[22:0];
  assign w_fb     = Op_B_in[22:0];
  assign w_nan_a  = (w_ea == 8'hFF) && (w_fa != 23'd0);
  assign w_nan_b  = (w_eb == 8'hFF) && (w_fb != 23'd0);
  assign w_inf_a  = (w_ea == 8'hFF) && (w_fa == 23'd0);
  assign w_inf_b  = (w_eb == 8'hFF) && (w_fb == 23'd0);
  assign w_zero_a = (w_ea == 8'd0);
  assign w_zero_b = (w_eb == 8'd0);

  logic        w_a_big, w_sl, w_eff_sub;
  logic [7:0]  w_el, w_es, w_diff;
  logic [23:0] w_sig_l, w_sig_s;
  logic [49:0] w_shifted;
  logic [26:0] w_large, w_small;
  logic [27:0] w_sum;

  // Operand with the larger magnitude goes first; the smaller one is aligned
  // into a 24-bit significand plus guard, round and sticky.
  always_comb begin
    w_a_big   = {w_ea, w_fa} >= {w_eb, w_fb};
    w_sl      = w_a_big ? w_sa : w_sb;
    w_el      = w_a_big ? w_ea : w_eb;
    w_es      = w_a_big ? w_eb : w_ea;
    w_sig_l   = {1'b1, (w_a_big ? w_fa : w_fb)};
    w_sig_s   = {1'b1, (w_a_big ? w_fb : w_fa)};
    w_diff    = w_el - w_es;
    w_shifted = {w_sig_s, 26'd0} >> w_diff;
    w_small   = (w_diff >= 8'd26) ? 27'd1 : {w_shifted[49:24], |w_shifted[23:0]};
    w_large   = {w_sig_l, 3'b000};
    w_eff_sub = w_sa ^ w_sb;
    w_sum     = w_eff_sub ? ({1'b0, w_large} - {1'b0, w_small})
                          : ({1'b0, w_large} + {1'b0, w_small});
  end

  logic [4:0] w_lzc;

  always_comb begin
    w_lzc = 5'd0;
    for (int i = 0; i < 27; i++) begin
      if (w_sum[i]) w_lzc = 5'(26 - i);
    end
  end

  logic [26:0]       w_norm;
  logic signed [9:0] w_exp, w_exp_f;
  logic              w_rup, w_inexact;
  logic [24:0]       w_mant;
  logic [22:0]       w_frac;

  always_comb begin
    if (w_sum[27]) begin
      w_norm = {w_sum[27:2], w_sum[1] | w_sum[0]};
      w_exp  = $signed({2'b00, w_el}) + 10'sd1;
    end else begin
      w_norm = w_sum[26:0] << w_lzc;
      w_exp  = $signed({2'b00, w_el}) - $signed({5'd0, w_lzc});
    end
    // Bit 3 is the result LSB; bits 2..0 are guard, round, sticky.
    w_rup     = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
    w_inexact = |w_norm[2:0];
    w_mant    = {1'b0, w_norm[26:3]} + {24'd0, w_rup};
    if (w_mant[24]) begin
      w_frac  = w_mant[23:1];
      w_exp_f = w_exp + 10'sd1;
    end else begin
      w_frac  = w_mant[22:0];
      w_exp_f = w_exp;
    end
  end

  logic [31:0] w_result;
  logic [3:0]  w_status;

  always_comb begin
    w_result = {w_sl, w_exp_f[7:0], w_frac};
    w_status = {3'b000, w_inexact};
    if (w_nan_a || w_nan_b) begin
      w_result = QNAN;
      w_status = 4'b1000;
    end else if (w_inf_a && w_inf_b && (w_sa != w_sb)) begin
      w_result = QNAN;
      w_status = 4'b1000;
    end else if (w_inf_a) begin
      w_result = {w_sa, 8'hFF, 23'd0};
      w_status = 4'b0000;
    end else if (w_inf_b) begin
      w_result = {w_sb, 8'hFF, 23'd0};
      w_status = 4'b0000;
    end else if (w_zero_a && w_zero_b) begin
      w_result = {w_sa & w_sb, 31'd0};
      w_status = 4'b0000;
    end else if (w_zero_a) begin
      w_result = {w_sb, w_eb, w_fb};
      w_status = 4'b0000;
    end else if (w_zero_b) begin
      w_result = {w_sa, w_ea, w_fa};
      w_status = 4'b0000;
    end else if (w_sum == 28'd0) begin
      w_result = 32'd0;
      w_status = 4'b0000;
    end else if (w_exp_f >= 10'sd255) begin
      w_result = {w_sl, 8'hFF, 23'd0};
      w_status = 4'b0101;
    end else if (w_exp_f <= 10'sd0) begin
      w_result = {w_sl, 31'd0};
      w_status = 4'b0011;
    end
  end

  logic [31:0] r_data;
  logic [3:0]  r_status;

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      r_data   <= 32'd0;
      r_status <= 4'd0;
    end else begin
      r_data   <= w_result;
      r_status <= w_status;
    end
  end

  assign data_out   = r_data;
  assign status_out = r_status;

endmodule

// File: tb/tb_minha_fpu.sv
// Directed-vector bench for minha_fpu: hand-computed results and flags,
// one-cycle latency and asynchronous clear.
module tb_minha_fpu;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] op_a, op_b;
  logic        op_sel;
  logic [31:0] data_out;
  logic [3:0]  status_out;

  int checks = 0;
  int errors = 0;

  minha_fpu dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .Op_A_in    (op_a),
    .Op_B_in    (op_b),
    .op_select  (op_sel),
    .data_out   (data_out),
    .status_out (status_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [35:0] got, input logic [35:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h/%b expected=%h/%b", tag, got[35:4], got[3:0], exp[35:4], exp[3:0]);
    end else begin
      $display("ok   %s result=%h status=%b", tag, got[35:4], got[3:0]);
    end
  endtask

  task automatic run_vec(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic op, input logic [31:0] exp_d, input logic [3:0] exp_s);
    @(negedge clk);
    op_a   = a;
    op_b   = b;
    op_sel = op;
    @(posedge clk);
    #1;
    check(tag, {data_out, status_out}, {exp_d, exp_s});
  endtask

  initial begin
    reset_n = 1'b1;
    op_a    = 32'h3F80_0000;
    op_b    = 32'h3F80_0000;
    op_sel  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {data_out, status_out}, 36'd0);
    @(negedge clk);
    reset_n = 1'b0;

    run_vec("add_1_1",      32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, 4'b0000);
    run_vec("sub_2_1",      32'h4000_0000, 32'h3F80_0000, 1'b1, 32'h3F80_0000, 4'b0000);
    run_vec("sub_1_2",      32'h3F80_0000, 32'h4000_0000, 1'b1, 32'hBF80_0000, 4'b0000);
    run_vec("sub_m2_1",     32'hC000_0000, 32'h3F80_0000, 1'b1, 32'hC040_0000, 4'b0000);
    run_vec("inf_sub_inf",  32'h7F80_0000, 32'h7F80_0000, 1'b1, 32'h7FC0_0000, 4'b1000);
    run_vec("inf_add_1",    32'h7F80_0000, 32'h3F80_0000, 1'b0, 32'h7F80_0000, 4'b0000);
    run_vec("cancel",       32'h3F80_0000, 32'hBF80_0000, 1'b0, 32'h0000_0000, 4'b0000);
    run_vec("overflow",     32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000, 4'b0101);
    run_vec("tie_even",     32'h3F80_0001, 32'h3F80_0002, 1'b0, 32'h4000_0002, 4'b0001);
    run_vec("add_frac",     32'h3FC5_1EB8, 32'h3F9D_70A4, 1'b0, 32'h4031_47AE, 4'b0000);
    run_vec("align_8_1",    32'h4100_0000, 32'h3F80_0000, 1'b0, 32'h4110_0000, 4'b0000);
    run_vec("align_15_25",  32'h3FC0_0000, 32'h4020_0000, 1'b0, 32'h4080_0000, 4'b0000);
    run_vec("nan_in",       32'h7FC0_0001, 32'h3F80_0000, 1'b0, 32'h7FC0_0000, 4'b1000);
    run_vec("negz_negz",    32'h8000_0000, 32'h8000_0000, 1'b0, 32'h8000_0000, 4'b0000);
    run_vec("negz_sub_negz",32'h8000_0000, 32'h8000_0000, 1'b1, 32'h0000_0000, 4'b0000);
    run_vec("zero_add_x",   32'h0000_0000, 32'hC000_0000, 1'b0, 32'hC000_0000, 4'b0000);
    run_vec("underflow",    32'h0080_0001, 32'h0080_0000, 1'b1, 32'h0000_0000, 4'b0011);
    run_vec("half_ulp_tie", 32'h3F80_0000, 32'h3380_0000, 1'b0, 32'h3F80_0000, 4'b0001);
    run_vec("sticky_only",  32'h3F80_0000, 32'h3300_0000, 1'b0, 32'h3F80_0000, 4'b0001);

    // New operands must not reach the output before the next rising edge.
    @(negedge clk);
    op_a   = 32'h4100_0000;
    op_b   = 32'h3F80_0000;
    op_sel = 1'b0;
    #2;
    check("hold_before_edge", {data_out, status_out}, {32'h3F80_0000, 4'b0001});
    @(posedge clk);
    #1;
    check("one_edge_latency", {data_out, status_out}, {32'h4110_0000, 4'b0000});

    // Asynchronous clear between edges, held while asserted.
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("async_clear", {data_out, status_out}, 36'd0);
    @(posedge clk);
    #1;
    check("clear_held", {data_out, status_out}, 36'd0);
    @(negedge clk);
    reset_n = 1'b0;
    op_a    = 32'h3F80_0000;
    op_b    = 32'h3F80_0000;
    @(posedge clk);
    #1;
    check("after_release", {data_out, status_out}, {32'h4000_0000, 4'b0000});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
